// File: rtl/bexkat2_dbus_resp_pkg.sv
// Shared type definitions for the bexkat CPU core and its data-bus slaves.
// The data-bus responder state enum sits next to the CPU control enums so
// both sides of the bus agree on encodings.
package bexkat1Def;

  // CPU control enums
  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } cpu_state_t;

  typedef enum logic [1:0] {
    MEM_NONE, MEM_READ, MEM_WRITE
  } mem_op_t;

  // Data-bus responder states
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_ACK  = 2'd2,
    R_ERR  = 2'd3
  } resp_state_t;

  // Wait-state counter width (WAIT ranges 0..15)
  localparam int WAIT_W = 4;

endpackage

// File: rtl/bexkat2_wordram.sv
// Single-port word RAM, 2**AW x 32, per-byte write enables, registered read.
// Byte enable bit b writes bits [8b+7:8b]; no reset on the array contents.
module bexkat2_wordram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  // Byte-masked write and synchronous read of the addressed word
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bexkat2_dbus_resp.sv
// CPU data-bus responder: latches a request, inserts WAIT wait states,
// then pulses ack_o (or err_o) for one cycle and returns to idle.
// Optional macro BEXKAT2_DBUS_ERR_EN: addresses above the RAM window
// produce err_o instead of aliasing into the RAM.
//
// Handshake: a transfer starts when cyc_i & stb_i are seen in R_IDLE; the
// initiator keeps cyc_i high until ack_o/err_o; dropping cyc_i during the
// wait states aborts with no write and no response. stb_i is ignored
// outside R_IDLE. dat_o is meaningful only during a read ack and is 0
// otherwise.
module bexkat2_dbus_resp
  import bexkat1Def::*;
#(
  parameter int AW   = 10,
  parameter int WAIT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output resp_state_t dbg_state
);

  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT);

  resp_state_t       state;
  logic [WAIT_W-1:0] cnt;
  logic              ack_q;
  logic              err_q;
  logic              we_q;
  logic              oor_q;
  logic [3:0]        sel_q;
  logic [AW-1:0]     adr_q;
  logic [31:0]       dat_q;
  logic [31:0]       rdata;
  logic [AW-1:0]     ram_addr;
  logic [3:0]        ram_we;
  logic              oor_in;
  logic              unused_bits;

`ifdef BEXKAT2_DBUS_ERR_EN
  assign oor_in = (adr_i >> (AW + 2)) != 32'd0;
`else
  assign oor_in = 1'b0;
`endif

  // Byte-offset bits never select anything; upper bits only feed the decode
  assign unused_bits = ^{adr_i[1:0], adr_i[31:AW+2]};

  // RAM sees the live address while idle so read data is ready by the ack
  // cycle even with zero wait states; afterwards it holds the latched one.
  assign ram_addr = (state == R_IDLE) ? adr_i[AW+1:2] : adr_q;
  assign ram_we   = (state == R_ACK && we_q) ? sel_q : 4'b0000;

  bexkat2_wordram #(.AW(AW)) u_ram (
    .clk   (clk_i),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (dat_q),
    .rdata (rdata)
  );

  // Responder FSM with registered ack/err pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= R_IDLE;
      cnt   <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      we_q  <= 1'b0;
      oor_q <= 1'b0;
      sel_q <= '0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        R_IDLE: begin
          if (cyc_i && stb_i) begin
            adr_q <= adr_i[AW+1:2];
            we_q  <= we_i;
            sel_q <= sel_i;
            dat_q <= dat_i;
            oor_q <= oor_in;
            cnt   <= WAIT_LD;
            if (WAIT_LD != '0) begin
              state <= R_WAIT;
            end else if (oor_in) begin
              state <= R_ERR;
              err_q <= 1'b1;
            end else begin
              state <= R_ACK;
              ack_q <= 1'b1;
            end
          end
        end
        R_WAIT: begin
          if (!cyc_i) begin
            state <= R_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt <= 1) begin
              if (oor_q) begin
                state <= R_ERR;
                err_q <= 1'b1;
              end else begin
                state <= R_ACK;
                ack_q <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= R_IDLE;
        end
      endcase
    end
  end

  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign dat_o     = (ack_q && !we_q) ? rdata : 32'd0;
  assign dbg_state = state;

endmodule

// File: tb/tb_bexkat2_dbus_resp.sv
// Directed bench for bexkat2_dbus_resp: three instances with WAIT = 1, 3, 0
// share clock and reset; each has its own request signals.
module tb_bexkat2_dbus_resp;
  import bexkat1Def::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc   [3];
  logic        stb   [3];
  logic        we    [3];
  logic [3:0]  sel   [3];
  logic [31:0] adr   [3];
  logic [31:0] wdat  [3];
  logic [31:0] dat_r [3];
  logic        ack   [3];
  logic        err   [3];
  resp_state_t st    [3];

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  bexkat2_dbus_resp #(.AW(10), .WAIT(1)) dut_w1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .sel_i(sel[0]), .adr_i(adr[0]), .dat_i(wdat[0]), .dat_o(dat_r[0]),
    .ack_o(ack[0]), .err_o(err[0]), .dbg_state(st[0]));

  bexkat2_dbus_resp #(.AW(10), .WAIT(3)) dut_w3 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .sel_i(sel[1]), .adr_i(adr[1]), .dat_i(wdat[1]), .dat_o(dat_r[1]),
    .ack_o(ack[1]), .err_o(err[1]), .dbg_state(st[1]));

  bexkat2_dbus_resp #(.AW(10), .WAIT(0)) dut_w0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]),
    .sel_i(sel[2]), .adr_i(adr[2]), .dat_i(wdat[2]), .dat_o(dat_r[2]),
    .ack_o(ack[2]), .err_o(err[2]), .dbg_state(st[2]));

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: one transfer, stb for one cycle, inputs scrambled after latch
  task automatic xfer(input int k, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d,
                      input int exp_lat, input logic exp_err,
                      input logic [31:0] exp_dat, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = a; wdat[k] = d;
    @(posedge clk); #1;
    stb[k] = 1'b0; we[k] = ~w; sel[k] = ~s; adr[k] = 32'h0000_03FC; wdat[k] = ~d;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ack[k] || err[k]) seen = 1'b1;
    end
    check({tag, " lat"}, 32'(lat), 32'(exp_lat));
    check({tag, " ack"}, {31'd0, ack[k]}, {31'd0, ~exp_err});
    check({tag, " err"}, {31'd0, err[k]}, {31'd0, exp_err});
    if (!w) check({tag, " dat"}, dat_r[k], exp_dat);
    cyc[k] = 1'b0; we[k] = 1'b0; sel[k] = 4'h0; adr[k] = '0; wdat[k] = '0;
  endtask

  initial begin
    bit any_resp;
    for (int k = 0; k < 3; k++) begin
      cyc[k] = 0; stb[k] = 0; we[k] = 0; sel[k] = 0; adr[k] = 0; wdat[k] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst ack%0d", k), {31'd0, ack[k]}, 32'd0);
      check($sformatf("rst err%0d", k), {31'd0, err[k]}, 32'd0);
      check($sformatf("rst dat%0d", k), dat_r[k], 32'd0);
      check($sformatf("rst st%0d", k), 32'(st[k]), 32'(R_IDLE));
    end
    rst = 1'b0;

    // WAIT=1: full write, read back, byte write, read back
    xfer(0, 1, 4'b1111, 32'h10, 32'h1234_5678, 2, 0, 32'h0, "w1 wr");
    xfer(0, 0, 4'b1111, 32'h10, 32'h0, 2, 0, 32'h1234_5678, "w1 rd");
    xfer(0, 1, 4'b0100, 32'h10, 32'hAABB_CCDD, 2, 0, 32'h0, "w1 bwr");
    xfer(0, 0, 4'b0000, 32'h10, 32'h0, 2, 0, 32'h12BB_5678, "w1 brd");

    // Out-of-range address: error with macro, alias of word 0 without
    xfer(0, 1, 4'b1111, 32'h0, 32'hCAFE_F00D, 2, 0, 32'h0, "w1 wr0");
`ifdef BEXKAT2_DBUS_ERR_EN
    xfer(0, 0, 4'b1111, 32'h0000_1000, 32'h0, 2, 1, 32'h0, "oor");
    xfer(0, 1, 4'b1111, 32'h0000_1000, 32'h5555_5555, 2, 1, 32'h0, "oor wr");
`else
    xfer(0, 0, 4'b1111, 32'h0000_1000, 32'h0, 2, 0, 32'hCAFE_F00D, "alias");
`endif
    xfer(0, 0, 4'b1111, 32'h0, 32'h0, 2, 0, 32'hCAFE_F00D, "w1 rd0");

    // WAIT=3: abort by dropping cyc two cycles after stb
    xfer(1, 1, 4'b1111, 32'h20, 32'h55AA_55AA, 4, 0, 32'h0, "w3 wr");
    @(negedge clk);
    cyc[1] = 1; stb[1] = 1; we[1] = 1; sel[1] = 4'hF; adr[1] = 32'h20; wdat[1] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    stb[1] = 0;
    @(negedge clk);
    @(negedge clk);
    cyc[1] = 0;
    any_resp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack[1] || err[1]) any_resp = 1'b1;
    end
    check("abort resp", {31'd0, any_resp}, 32'd0);
    check("abort st", 32'(st[1]), 32'(R_IDLE));
    we[1] = 0; sel[1] = 0; adr[1] = 0; wdat[1] = 0;
    xfer(1, 0, 4'b1111, 32'h20, 32'h0, 4, 0, 32'h55AA_55AA, "abort rd");

    // WAIT=3: reset during wait states discards the write
    xfer(1, 1, 4'b1111, 32'h30, 32'h0BAD_BEEF, 4, 0, 32'h0, "w3 wr30");
    @(negedge clk);
    cyc[1] = 1; stb[1] = 1; we[1] = 1; sel[1] = 4'hF; adr[1] = 32'h30; wdat[1] = 32'h1111_1111;
    @(posedge clk); #1;
    stb[1] = 0;
    @(negedge clk);
    check("pre-rst st", 32'(st[1]), 32'(R_WAIT));
    rst = 1'b1;
    #1;
    check("rst ack", {31'd0, ack[1]}, 32'd0);
    check("rst st", 32'(st[1]), 32'(R_IDLE));
    check("rst dat", dat_r[1], 32'd0);
    @(negedge clk);
    rst = 1'b0; cyc[1] = 0; we[1] = 0; sel[1] = 0; adr[1] = 0; wdat[1] = 0;
    xfer(1, 0, 4'b1111, 32'h30, 32'h0, 4, 0, 32'h0BAD_BEEF, "rst rd30");
    xfer(0, 0, 4'b1111, 32'h10, 32'h0, 2, 0, 32'h12BB_5678, "rst keep");

    // WAIT=0: stb held high gives ack on every other cycle
    xfer(2, 1, 4'b1111, 32'h40, 32'h0000_4040, 1, 0, 32'h0, "w0 wr");
    @(negedge clk);
    cyc[2] = 1; stb[2] = 1; we[2] = 0; sel[2] = 4'hF; adr[2] = 32'h40;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("b2b ack%0d", i), {31'd0, ack[2]}, {31'd0, (i % 2) == 0});
      check($sformatf("b2b dat%0d", i), dat_r[2], ((i % 2) == 0) ? 32'h0000_4040 : 32'd0);
      check($sformatf("b2b err%0d", i), {31'd0, err[2]}, 32'd0);
    end
    cyc[2] = 0; stb[2] = 0;
    @(negedge clk);
    check("b2b tail ack", {31'd0, ack[2]}, 32'd0);
    check("b2b tail st", 32'(st[2]), 32'(R_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bexkat2_dbus_resp.md
BEXKAT2_DBUS_RESP -- requirements
Module: bexkat2_dbus_resp

Interface
REQ-001 SHALL have parameter AW, default 10, meaning word-address width (memory depth 2**AW 32-bit words).
REQ-002 SHALL have parameter WAIT, default 1, meaning wait states inserted before ack (0..15).
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cyc_i  input  1  bus cycle active (CPU data-bus initiator).
REQ-006 SHALL have port stb_i  input  1  transfer strobe.
REQ-007 SHALL have port we_i  input  1  1=write, 0=read.
REQ-008 SHALL have port sel_i  input  4  byte enables; sel_i[3] = bits 31:24 = lowest byte address (big-endian).
REQ-009 SHALL have port adr_i  input  32  byte address; word index adr_i[AW+1:2]; adr_i[1:0] ignored.
REQ-010 SHALL have port dat_i  input  32  write data.
REQ-011 SHALL have port dat_o  output  32  read data, valid only while ack_o=1.
REQ-012 SHALL have port ack_o  output  1  single-cycle transfer-complete pulse.
REQ-013 SHALL have port err_o  output  1  single-cycle error pulse (tied 0 without BEXKAT2_DBUS_ERR_EN).

Function
REQ-014 SHALL implement states R_IDLE, R_WAIT, R_ACK, R_ERR.
REQ-015 R_IDLE: on cyc_i&stb_i SHALL latch adr_i, we_i, sel_i, dat_i and load wait counter with WAIT; go R_WAIT if WAIT>0, else R_ACK (or R_ERR per REQ-022).
REQ-016 R_WAIT: counter SHALL decrement each cycle; on reaching 1, next state R_ACK/R_ERR.
REQ-017 Latency: ack_o SHALL assert exactly WAIT+1 cycles after the cycle stb_i is sampled in R_IDLE.
REQ-018 R_ACK: ack_o=1 for exactly one cycle; write SHALL commit to storage at the end of this cycle, only bytes with sel bit set; read: dat_o = stored word (all 32 bits, sel ignored); then R_IDLE.
REQ-019 After every ack/err SHALL spend at least one cycle in R_IDLE; stb_i held high SHALL start a new transfer from that cycle.
REQ-020 cyc_i deasserted in R_WAIT SHALL abort: go R_IDLE next cycle, no write, no ack_o/err_o.
REQ-021 Inputs changing after the latch cycle SHALL not affect the transfer; stb_i in R_WAIT/R_ACK/R_ERR ignored.
REQ-022 Out of range = adr_i[31:AW+2] nonzero; with BEXKAT2_DBUS_ERR_EN SHALL go to R_ERR instead of R_ACK (same latency), no write, dat_o=0.
REQ-023 dat_o SHALL be 0 whenever ack_o=0.
REQ-024 ack_o and err_o SHALL never both be 1.

Reset
REQ-025 rst_i SHALL force R_IDLE, ack_o=0, err_o=0, dat_o=0, counter=0 immediately, including mid-transfer (pending write discarded).
REQ-026 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro BEXKAT2_DBUS_ERR_EN defined: out-of-range decode and err_o per REQ-022.
REQ-028 Macro undefined: upper address bits ignored, accesses alias modulo 2**AW words, err_o constant 0, R_ERR unreachable.

Structure
REQ-029 resp_state_t (R_IDLE, R_WAIT, R_ACK, R_ERR, 2 bits) SHALL live in package bexkat1Def beside the CPU control enums.
REQ-030 Storage SHALL be sub-module bexkat2_wordram: single-port, 2**AW x 32, 4 byte-write enables, synchronous read.

Verification
REQ-031 WAIT=1: write 0x12345678 sel=1111 adr=0x10, then read adr=0x10 -> ack 2 cycles after each stb, dat_o=0x12345678.
REQ-032 Byte write 0xAABBCCDD sel=0100 adr=0x10 over prior 0x12345678 -> read returns 0x12BB5678.
REQ-033 WAIT=3, cyc_i dropped 2 cycles after stb on write 0xFFFFFFFF adr=0x20 -> no ack; read adr=0x20 returns prior value.
REQ-034 rst_i pulsed while in R_WAIT of write adr=0x30 -> ack_o=0 same cycle, state R_IDLE, word 0x30 unchanged.
REQ-035 ERR_EN, AW=10, read adr=0x00001000 -> err_o one pulse at WAIT+1, ack_o=0, dat_o=0; without macro same access returns word 0.
REQ-036 WAIT=0, stb held high for 3 back-to-back reads -> ack pattern 1,0,1,0,1 (one idle cycle between).
